// File: rtl/vga_layout_pkg.sv
// vga_layout_pkg: screen layout constants, ROM chip selects and digit row base table
package vga_layout_pkg;
   localparam int HRES      = 640;
   localparam int DIG_W     = 40;
   localparam int DIG_H     = 60;
   localparam int DIG_X0    = 140;
   localparam int DIG_PITCH = 60;
   localparam int DIG_Y0    = 200;
   localparam int NUM_DIG   = 6;
   localparam int CRONO_W   = 100;
   localparam int CRONO_H   = 40;
   localparam int CRONO_X   = 270;
   localparam int CRONO_Y   = 300;
   typedef logic [18:0] rom_addr_t;
   typedef enum logic [1:0] {
      CS_INTERFAZ = 2'b00,
      CS_DIGITOS  = 2'b01,
      CS_CRONO    = 2'b11
   } cs_t;
   // first Numeros address of digit n (n*DIG_H*DIG_W), kept as a table so no multiplier is built
   localparam rom_addr_t DIG_ROW_BASE [10] = '{
      19'd0, 19'd2400, 19'd4800, 19'd7200, 19'd9600,
      19'd12000, 19'd14400, 19'd16800, 19'd19200, 19'd21600
   };
   function automatic logic [9:0] slot_x(input int k);
      return 10'(DIG_X0 + k * DIG_PITCH);
   endfunction
endpackage

// File: rtl/vga_window_hit.sv
// vga_window_hit: half-open rectangle test with window-local coordinates
//   x, y   : pixel position
//   x0, y0 : window top-left corner
//   w, h   : window size
//   hit    : x0<=x<x0+w && y0<=y<y0+h
//   lx, ly : x-x0, y-y0 (meaningful only when hit)
module vga_window_hit (
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [9:0] x0,
   input  logic [9:0] y0,
   input  logic [9:0] w,
   input  logic [9:0] h,
   output logic       hit,
   output logic [9:0] lx,
   output logic [9:0] ly
);
   logic [10:0] x_end, y_end;
   assign x_end = {1'b0, x0} + {1'b0, w};
   assign y_end = {1'b0, y0} + {1'b0, h};
   assign hit   = x >= x0 && {1'b0, x} < x_end && y >= y0 && {1'b0, y} < y_end;
   assign lx    = x - x0;
   assign ly    = y - y0;
endmodule

// File: rtl/vga_rom_addr_gen.sv
// vga_rom_addr_gen: maps the current VGA pixel to a VROMs chip select and address, and blanks ROM data to the DAC
//   CLK, RST_n            : pixel clock, synchronous active-low reset
//   PixelX, PixelY        : current pixel from the sync generator
//   VideoOn, FrameStart   : active-area flag, once-per-frame pulse (loads the digit/crono shadows)
//   Digits, CronoOn       : BCD digits (slot 0 in [3:0]) and crono sprite enable
//   ChipSelector, Address : to VROMs, one cycle after the pixel
//   RomData               : VROMs data, one cycle after Address
//   RGB                   : {R,G,B} to the DAC, three cycles after the pixel
module vga_rom_addr_gen
   import vga_layout_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RST_n,
   input  logic [9:0]             PixelX,
   input  logic [9:0]             PixelY,
   input  logic                   VideoOn,
   input  logic                   FrameStart,
   input  logic [4*NUM_DIG-1:0]   Digits,
   input  logic                   CronoOn,
   output logic [1:0]             ChipSelector,
   output logic [18:0]            Address,
   input  logic [5:0]             RomData,
   output logic [5:0]             RGB
);
   logic [4*NUM_DIG-1:0] dig_s;
   logic                 crono_s;
   logic [1:0]           von;
   logic [NUM_DIG:0]     hit;
   logic [9:0]           lx [NUM_DIG+1];
   logic [9:0]           ly [NUM_DIG+1];
   cs_t                  cs_nxt;
   rom_addr_t            addr_nxt;
   rom_addr_t            bg_addr;
   for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
      vga_window_hit u_hit (
         .x(PixelX), .y(PixelY),
         .x0(slot_x(k)), .y0(10'(DIG_Y0)), .w(10'(DIG_W)), .h(10'(DIG_H)),
         .hit(hit[k]), .lx(lx[k]), .ly(ly[k])
      );
   end
   vga_window_hit u_crono (
      .x(PixelX), .y(PixelY),
      .x0(10'(CRONO_X)), .y0(10'(CRONO_Y)), .w(10'(CRONO_W)), .h(10'(CRONO_H)),
      .hit(hit[NUM_DIG]), .lx(lx[NUM_DIG]), .ly(ly[NUM_DIG])
   );
   // y*640 = y*512 + y*128
   assign bg_addr = (rom_addr_t'(PixelY) << 9) + (rom_addr_t'(PixelY) << 7) + rom_addr_t'(PixelX);
   // descending scan so the lowest-numbered slot wins; crono then overrides, blanking overrides all
   always_comb begin
      cs_nxt   = CS_INTERFAZ;
      addr_nxt = bg_addr;
      for (int i = NUM_DIG - 1; i >= 0; i--) begin
         if (hit[i] && dig_s[4*i +: 4] <= 4'd9) begin
            cs_nxt   = CS_DIGITOS;
            addr_nxt = DIG_ROW_BASE[dig_s[4*i +: 4]] + (rom_addr_t'(ly[i]) << 5) + (rom_addr_t'(ly[i]) << 3)
                     + rom_addr_t'(lx[i]);
         end
      end
      if (crono_s && hit[NUM_DIG]) begin
         cs_nxt   = CS_CRONO;
         addr_nxt = (rom_addr_t'(ly[NUM_DIG]) << 6) + (rom_addr_t'(ly[NUM_DIG]) << 5)
                  + (rom_addr_t'(ly[NUM_DIG]) << 2) + rom_addr_t'(lx[NUM_DIG]);
      end
      if (!VideoOn) begin
         cs_nxt   = CS_INTERFAZ;
         addr_nxt = '0;
      end
   end
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         dig_s        <= '0;
         crono_s      <= 1'b0;
         ChipSelector <= CS_INTERFAZ;
         Address      <= '0;
         von          <= '0;
         RGB          <= '0;
      end else begin
         if (FrameStart) begin
            dig_s   <= Digits;
            crono_s <= CronoOn;
         end
         ChipSelector <= cs_nxt;
         Address      <= addr_nxt;
         von          <= {von[0], VideoOn};
         RGB          <= von[1] ? RomData : 6'b0;
      end
   end
endmodule
